// File: rtl/ext_signals_input_conditioner.sv
// Pad receive conditioning: per-pad synchroniser, glitch filter and edge detect,
// then per-pad routing of level or edge pulse onto the external input vector.
module ext_signals_input_conditioner #(
  parameter int N_PADS      = 10,
  parameter int N_VECTOR    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic [N_PADS-1:0]     IO_Block_Y,
  input  logic [8*N_PADS-1:0]   EXT_SelectInput,
  output logic [N_VECTOR-1:0]   EXT_InputsVectorSignals,
  output logic [N_PADS-1:0]     EXT_InputsFiltered
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [N_PADS-1:0]   r_sync [SYNC_STAGES];
  logic [CNT_W-1:0]    r_cnt  [N_PADS];
  logic [N_PADS-1:0]   r_filt;
  logic [N_PADS-1:0]   r_filt_d;
  logic [N_VECTOR-1:0] r_vec;
  logic [N_PADS-1:0]   r_filt_out;

  logic [N_PADS-1:0]   w_sync;
  logic [N_PADS-1:0]   w_rise;
  logic [N_PADS-1:0]   w_fall;
  logic [N_PADS-1:0]   w_contrib;
  logic [N_VECTOR-1:0] w_vec;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = r_filt & ~r_filt_d;
  assign w_fall = ~r_filt & r_filt_d;

  // Synchroniser chain
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= IO_Block_Y;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Glitch filter: a new level is accepted only after FILTER_LEN consecutive mismatches
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < N_PADS; i++) r_cnt[i] <= '0;
      r_filt   <= '0;
      r_filt_d <= '0;
    end else begin
      r_filt_d <= r_filt;
      for (int i = 0; i < N_PADS; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filt[i] <= w_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_contrib = '0;
    for (int i = 0; i < N_PADS; i++) begin
      case (EXT_SelectInput[8*i+5 +: 2])
        2'b00:   w_contrib[i] = r_filt[i];
        2'b01:   w_contrib[i] = w_rise[i];
        2'b10:   w_contrib[i] = w_fall[i];
        default: w_contrib[i] = w_rise[i] | w_fall[i];
      endcase
      if (!EXT_SelectInput[8*i+7]) w_contrib[i] = 1'b0;
    end
  end

  // Routing: pads sharing a destination are OR-merged; out-of-range indices drop out
  always_comb begin
    w_vec = '0;
    for (int i = 0; i < N_PADS; i++) begin
      if (int'(EXT_SelectInput[8*i +: 5]) < N_VECTOR)
        w_vec[EXT_SelectInput[8*i +: 5]] = w_vec[EXT_SelectInput[8*i +: 5]] | w_contrib[i];
    end
  end

  // Output registers
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_vec      <= '0;
      r_filt_out <= '0;
    end else begin
      r_vec      <= w_vec;
      r_filt_out <= r_filt;
    end
  end

  assign EXT_InputsVectorSignals = r_vec;
  assign EXT_InputsFiltered      = r_filt_out;

endmodule

// File: tb/tb_ext_signals_input_conditioner.sv
// Directed bench for ext_signals_input_conditioner: reset, glitch rejection,
// edge modes, OR-merge, reconfiguration and disabled routing.
module tb_ext_signals_input_conditioner;

  logic        Clock;
  logic        Reset_N;
  logic [9:0]  pads;
  logic [79:0] cfg;
  logic [31:0] vec;
  logic [9:0]  filt;
  logic [31:0] tra, trb;
  logic [9:0]  rnd;

  int n_checks = 0;
  int n_fail   = 0;

  ext_signals_input_conditioner #(
    .N_PADS(10), .N_VECTOR(32), .SYNC_STAGES(2), .FILTER_LEN(4)
  ) u_dut (
    .Clock                   (Clock),
    .Reset_N                 (Reset_N),
    .IO_Block_Y              (pads),
    .EXT_SelectInput         (cfg),
    .EXT_InputsVectorSignals (vec),
    .EXT_InputsFiltered      (filt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic set_cfg(input int p, input logic [7:0] b);
    cfg[8*p +: 8] = b;
  endtask

  // Trace two vector bits for nsteps edges; at step drop_at the pads take new_pads.
  task automatic trace(input int ba, input int bb, input int nsteps, input int drop_at,
                       input logic [9:0] new_pads, output logic [31:0] ta, output logic [31:0] tb);
    ta = '0;
    tb = '0;
    for (int k = 1; k <= nsteps; k++) begin
      step();
      ta[k] = vec[ba];
      tb[k] = vec[bb];
      if (k == drop_at) pads = new_pads;
    end
  endtask

  task automatic idle();
    pads = '0;
    cfg  = '0;
    settle(10);
  endtask

  initial begin
    Reset_N = 1'b0;
    pads    = 10'h3FF;
    cfg     = '0;
    set_cfg(0, 8'h85);
    settle(3);
    chk("rst_vec_hold", vec, 32'h0);
    chk("rst_filt_hold", {22'b0, filt}, 32'h0);

    // release with pad0 high: level on bit5 appears after edge e6 (step 7)
    pads    = 10'h001;
    Reset_N = 1'b1;
    trace(5, 5, 10, 0, 10'h001, tra, trb);
    chk("rst_latency", tra, 32'h0000_0780);
    chk("rst_vec", vec, 32'h20);
    chk("rst_filt", {22'b0, filt}, 32'h1);

    // asynchronous reset mid-operation
    #2;
    Reset_N = 1'b0;
    #1;
    chk("async_rst_vec", vec, 32'h0);
    chk("async_rst_filt", {22'b0, filt}, 32'h0);
    step();
    Reset_N = 1'b1;
    idle();

    // glitch rejection on pad3 -> bit0
    set_cfg(3, 8'h80);
    settle(2);
    pads = 10'h008;
    trace(0, 0, 16, 3, 10'h000, tra, trb);
    chk("glitch3", tra, 32'h0);
    pads = 10'h008;
    trace(0, 0, 16, 4, 10'h000, tra, trb);
    chk("pulse4", tra, 32'h0000_0780);
    idle();

    // rising on pad1 -> bit2, falling on pad2 -> bit3
    set_cfg(1, 8'hA2);
    set_cfg(2, 8'hC3);
    settle(2);
    pads = 10'h006;
    trace(2, 3, 24, 8, 10'h000, tra, trb);
    chk("rise_pulse", tra, 32'h0000_0080);
    chk("fall_pulse", trb, 32'h0000_8000);

    // either-edge on pad1 -> bit2
    set_cfg(1, 8'hE2);
    set_cfg(2, 8'h00);
    settle(2);
    pads = 10'h002;
    trace(2, 3, 24, 8, 10'h000, tra, trb);
    chk("either_pulse", tra, 32'h0000_8080);
    chk("either_other", trb, 32'h0);
    idle();

    // OR-merge of pads 4 and 7 on bit10
    set_cfg(4, 8'h8A);
    set_cfg(7, 8'h8A);
    pads = 10'h010;
    settle(8);
    chk("or_p4", vec, 32'h400);
    pads = 10'h090;
    settle(8);
    chk("or_both", vec, 32'h400);
    pads = 10'h080;
    settle(8);
    chk("or_p7", vec, 32'h400);
    pads = 10'h000;
    settle(8);
    chk("or_none", vec, 32'h0);

    // rise on pad4 and fall on pad7 together -> a single pulse on bit10
    pads = 10'h080;
    settle(8);
    set_cfg(4, 8'hAA);
    set_cfg(7, 8'hCA);
    settle(2);
    pads = 10'h010;
    trace(10, 10, 14, 0, 10'h010, tra, trb);
    chk("merge_pulse", tra, 32'h0000_0080);
    idle();

    // reconfiguration on a stable-high pad5 produces no pulse
    pads = 10'h020;
    settle(8);
    set_cfg(5, 8'hA1);
    trace(1, 1, 10, 0, 10'h020, tra, trb);
    chk("reconf_no_pulse", tra, 32'h0);
    set_cfg(5, 8'h81);
    step();
    chk("reconf_level", vec, 32'h2);
    idle();

    // disabled routes: vector stays 0 while filtered levels track the pads
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 10; p++) set_cfg(p, 8'($urandom_range(0, 127)));
      rnd  = 10'($urandom_range(0, 1023));
      pads = rnd;
      settle(8);
      chk("dis_vec", vec, 32'h0);
      chk("dis_filt", {22'b0, filt}, {22'b0, rnd});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
